ula_multiciclo: RTL and testbench

Parametrised multi-cycle ALU for the RISC-V datapath, succeeding the single-cycle add/sub ULA. It provides full RV64I/M-subset arithmetic, logic, shift and compare operations plus iterative unsigned multiply and divide. It keeps the immediate operand mux and the branch-comparison flags. Results are registered and delivered through a start/ready/valid handshake, so the control unit can stall on long operations.

---
 rtl/ula_multiciclo.sv | 110 +++++++++++
 tb/tb_ula_multiciclo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU with single-cycle ops, shift-add multiply and restoring divide behind a start/ready/valid handshake
module ula_multiciclo #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic            alu_src,
  input  logic [BITS-1:0] dina,
  input  logic [BITS-1:0] dinb,
  input  logic [BITS-1:0] imm,
  output logic            ready,
  output logic            valid,
  output logic [BITS-1:0] dout,
  output logic            flag_igual,
  output logic            flag_menor,
  output logic            flag_maior_igual_u,
  output logic            div_zero
);
  localparam int SH = $clog2(BITS);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] op_q;
  logic [BITS-1:0] a_q, b_q, c_q, b_in, alu_res, fin;
  logic [2*BITS-1:0] acc, acc_nx;
  logic [BITS:0] mul_sum, rem_sh, rem_sub;
  logic [SH:0] cnt;
  logic [SH-1:0] sh;
  logic iter_in, is_mul, ge;
  assign b_in = alu_src ? imm : dinb;
  assign sh = b_in[SH-1:0];
  assign iter_in = op >= 4'd10 && op <= 4'd13;
  assign is_mul = op_q[3:1] == 3'b101;
  assign ready = state == IDLE;
  assign valid = state == DONE;
  function automatic logic [2:0] cmp(input logic [BITS-1:0] x, input logic [BITS-1:0] y);
    return {x == y, $signed(x) < $signed(y), x >= y};
  endfunction
  always_comb begin
    alu_res = '0;
    case (op)
      4'd0: alu_res = dina + b_in;
      4'd1: alu_res = dina - b_in;
      4'd2: alu_res = dina & b_in;
      4'd3: alu_res = dina | b_in;
      4'd4: alu_res = dina ^ b_in;
      4'd5: alu_res = BITS'($signed(dina) < $signed(b_in));
      4'd6: alu_res = BITS'(dina < b_in);
      4'd7: alu_res = dina << sh;
      4'd8: alu_res = dina >> sh;
      4'd9: alu_res = $signed(dina) >>> sh;
      default: alu_res = '0;
    endcase
  end
  // acc holds {high, low}: product/multiplier for MUL, remainder/quotient for DIV
  always_comb begin
    mul_sum = {1'b0, acc[2*BITS-1:BITS]} + (acc[0] ? {1'b0, a_q} : '0);
    rem_sh = {acc[2*BITS-1:BITS], acc[BITS-1]};
    rem_sub = rem_sh - {1'b0, b_q};
    ge = rem_sh >= {1'b0, b_q};
    acc_nx = is_mul ? {mul_sum, acc[BITS-1:1]}
                    : {ge ? rem_sub[BITS-1:0] : rem_sh[BITS-1:0], acc[BITS-2:0], ge};
    fin = op_q[0] ? acc_nx[2*BITS-1:BITS] : acc_nx[BITS-1:0];
  end
  always_comb begin
    state_nx = state == IDLE ? (start ? (iter_in ? CALC : DONE) : IDLE)
             : state == CALC ? (cnt == (SH+1)'(1) ? DONE : CALC)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      dout <= '0;
      {flag_igual, flag_menor, flag_maior_igual_u} <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (ready && start) begin
        a_q <= dina;
        b_q <= b_in;
        c_q <= dinb;
        op_q <= op;
        if (iter_in) begin
          cnt <= (SH+1)'(BITS);
          acc <= {{BITS{1'b0}}, op[3:1] == 3'b101 ? b_in : dina};
        end else begin
          dout <= alu_res;
          {flag_igual, flag_menor, flag_maior_igual_u} <= cmp(dina, dinb);
          div_zero <= 1'b0;
        end
      end
      if (state == CALC) begin
        cnt <= cnt - (SH+1)'(1);
        acc <= acc_nx;
        if (cnt == (SH+1)'(1)) begin
          dout <= fin;
          {flag_igual, flag_menor, flag_maior_igual_u} <= cmp(a_q, c_q);
          div_zero <= !is_mul && b_q == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: drives 8- and 64-bit instances in lockstep against an arithmetic reference model
module tb_ula_multiciclo;
  logic clk = 0, reset = 1, start = 0, alu_src = 0;
  logic [3:0] op = '0;
  logic [63:0] dina = '0, dinb = '0, imm = '0;
  logic r8, v8, fi8, fm8, fu8, dz8, r64, v64, fi64, fm64, fu64, dz64;
  logic [7:0] d8;
  logic [63:0] d64;
  int cyc = 0, total = 0, bad = 0;
  int due[2] = '{-1, -1};
  int from[2] = '{-1, -1};
  int vcyc[2] = '{0, 0};
  logic [63:0] exp_d[2], got[2];
  logic [63:0] hold[2] = '{64'd0, 64'd0};
  logic [3:0] exp_f[2], got_f[2];
  logic [3:0] hold_f[2] = '{4'd0, 4'd0};
  logic vv[2], rr[2];
  logic [63:0] dd[2];
  logic [3:0] ff[2];

  ula_multiciclo #(.BITS(8)) u8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .alu_src(alu_src),
    .dina(dina[7:0]), .dinb(dinb[7:0]), .imm(imm[7:0]),
    .ready(r8), .valid(v8), .dout(d8),
    .flag_igual(fi8), .flag_menor(fm8), .flag_maior_igual_u(fu8), .div_zero(dz8)
  );
  ula_multiciclo #(.BITS(64)) u64 (
    .clk(clk), .reset(reset), .start(start), .op(op), .alu_src(alu_src),
    .dina(dina), .dinb(dinb), .imm(imm),
    .ready(r64), .valid(v64), .dout(d64),
    .flag_igual(fi64), .flag_menor(fm64), .flag_maior_igual_u(fu64), .div_zero(dz64)
  );

  always_comb begin
    vv[0] = v8; vv[1] = v64;
    rr[0] = r8; rr[1] = r64;
    dd[0] = {56'd0, d8}; dd[1] = d64;
    ff[0] = {fi8, fm8, fu8, dz8}; ff[1] = {fi64, fm64, fu64, dz64};
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int k, input string n, input logic [63:0] g, input logic [63:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s w=%0d got=%h exp=%h cyc=%0d", n, k ? 64 : 8, g, e, cyc);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return w == 64 ? '1 : (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] sx(input logic [63:0] x, input int w);
    return (w < 64 && x[w-1]) ? x | ~mask(w) : x;
  endfunction

  function automatic logic [63:0] model(input int w, input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    int s;
    logic [63:0] r;
    p = {64'd0, a} * {64'd0, b};
    s = int'(b[5:0]) % w;
    case (o)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = 64'($signed(sx(a, w)) < $signed(sx(b, w)));
      4'd6: r = 64'(a < b);
      4'd7: r = a << s;
      4'd8: r = a >> s;
      4'd9: r = $signed(sx(a, w)) >>> s;
      4'd10: r = p[63:0];
      4'd11: r = 64'(p >> w);
      4'd12: r = b == 0 ? '1 : a / b;
      4'd13: r = b == 0 ? a : a % b;
      default: r = '0;
    endcase
    return r & mask(w);
  endfunction

  task automatic issue(input logic [3:0] o, input logic s, input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
    int w;
    logic [63:0] m, x, y, c;
    @(negedge clk);
    op = o; alu_src = s; dina = a; dinb = b; imm = im; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    for (int k = 0; k < 2; k++) begin
      w = k ? 64 : 8;
      m = mask(w);
      x = a & m;
      y = (s ? im : b) & m;
      c = b & m;
      exp_d[k] = model(w, o, x, y);
      exp_f[k] = {x == c, $signed(sx(x, w)) < $signed(sx(c, w)), x >= c, (o == 4'd12 || o == 4'd13) && y == 0};
      from[k] = cyc;
      due[k] = cyc + ((o >= 4'd10 && o <= 4'd13) ? w : 0);
    end
    dina = ~a; dinb = ~b; imm = ~im; op = 4'd15; alu_src = ~s;
  endtask

  task automatic finish_op;
    while (cyc <= due[0] || cyc <= due[1]) @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] o, input logic s, input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
    issue(o, s, a, b, im);
    finish_op();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        check(k, "valid", 64'(vv[k]), 64'(cyc == due[k]));
        check(k, "ready", 64'(rr[k]), 64'(!(cyc >= from[k] && cyc <= due[k])));
        if (cyc == due[k]) begin
          hold[k] = exp_d[k];
          hold_f[k] = exp_f[k];
          got[k] = dd[k];
          got_f[k] = ff[k];
          vcyc[k] = cyc;
        end
        check(k, "dout", dd[k], hold[k]);
        check(k, "flags", 64'(ff[k]), 64'(hold_f[k]));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    run(4'd0, 1, 64'h05, 64'h05, 64'hFB);
    check(0, "add_lit", got[0], 64'h00);
    check(0, "add_flags_lit", 64'(got_f[0]), 64'b1010);
    check(0, "add_lat", 64'(vcyc[0] - from[0] + 1), 64'd1);
    run(4'd5, 0, 64'h80, 64'h01, 64'h0);
    check(0, "slt_lit", got[0], 64'h01);
    check(0, "slt_flags_lit", 64'(got_f[0]), 64'b0110);
    run(4'd6, 0, 64'h80, 64'h01, 64'h0);
    check(0, "sltu_lit", got[0], 64'h00);
    run(4'd9, 0, 64'h80, 64'h03, 64'h0);
    check(0, "sra_lit", got[0], 64'hF0);
    run(4'd8, 0, 64'h80, 64'h03, 64'h0);
    check(0, "srl_lit", got[0], 64'h10);
    run(4'd7, 0, 64'h81, 64'h09, 64'h0);
    check(0, "sll_lit", got[0], 64'h02);
    issue(4'd10, 0, 64'hFF, 64'hFF, 64'h0);
    repeat (2) @(negedge clk);
    start = 1; op = 4'd0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; op = 4'd14;
    @(negedge clk);
    start = 0;
    finish_op();
    check(0, "mul_lit", got[0], 64'h01);
    check(0, "mul_lat", 64'(vcyc[0] - from[0] + 1), 64'd9);
    run(4'd11, 0, 64'hFF, 64'hFF, 64'h0);
    check(0, "mulhu_lit", got[0], 64'hFE);
    run(4'd12, 0, 64'd100, 64'd7, 64'h0);
    check(0, "divu_lit", got[0], 64'h0E);
    check(0, "divu_dz_lit", 64'(got_f[0][0]), 64'd0);
    run(4'd13, 0, 64'd100, 64'd7, 64'h0);
    check(0, "remu_lit", got[0], 64'h02);
    run(4'd12, 0, 64'h2A, 64'h0, 64'h0);
    check(0, "divu0_lit", got[0], 64'hFF);
    check(0, "divu0_dz_lit", 64'(got_f[0][0]), 64'd1);
    run(4'd13, 0, 64'h2A, 64'h0, 64'h0);
    check(0, "remu0_lit", got[0], 64'h2A);
    run(4'd10, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0);
    check(1, "mul64_lit", got[1], 64'hFFFF_FFFE_0000_0001);
    check(1, "mul64_lat", 64'(vcyc[1] - from[1] + 1), 64'd65);
    for (int o = 0; o < 16; o++) begin
      run(4'(o), o % 3 == 0, 64'hF0F0_1234_8000_00A5, 64'h0000_0000_0000_0043, 64'hFFFF_FFFF_FFFF_FFF9);
      run(4'(o), 0, 64'h8000_0000_0000_0007, 64'h8000_0000_0000_0007, 64'h0);
    end
    issue(4'd10, 0, 64'hFFFF_FFFF, 64'h1234, 64'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    due = '{-1, -1};
    from = '{-1, -1};
    hold = '{64'd0, 64'd0};
    hold_f = '{4'd0, 4'd0};
    @(negedge clk);
    check(1, "rst_dout_lit", d64, 64'd0);
    check(1, "rst_ready_lit", 64'(r64), 64'd1);
    check(0, "rst_ready8_lit", 64'(r8), 64'd1);
    repeat (70) @(posedge clk);
    run(4'd0, 0, 64'd2, 64'd3, 64'h0);
    check(0, "add2_lit", got[0], 64'd5);
    check(1, "add2_64_lit", got[1], 64'd5);
    check(1, "add2_lat", 64'(vcyc[1] - from[1] + 1), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
